// File: rtl/cnt_sequencer.sv
// cnt_sequencer: drives the load/count controls of a downstream 4-bit
// up-counter. A run loads a preset, then counts until a given number of
// terminal counts have been seen, and closes with a one-cycle done pulse.
module cnt_sequencer (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] preset,
    input  logic [3:0] rounds,
    input  logic       tcount,
    output logic [3:0] in,
    output logic       ld,
    output logic       cnt,
    output logic       busy,
    output logic       done,
    output logic [3:0] rounds_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Last terminal count of the run: this tcount edge ends the RUN phase.
    logic last_tc;
    assign last_tc = tcount && (rounds_left == 4'd1);

    // Next-state decode; abort outranks tcount while a run is active.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (abort)                     state_d = IDLE;
                else if (rounds_left == 4'd0)  state_d = DONE;
                else                           state_d = RUN;
            end
            RUN: begin
                if (abort)        state_d = IDLE;
                else if (last_tc) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Captured load value and remaining-rounds counter; both frozen outside IDLE
    // except for the decrement on tcount and the clear on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in          <= 4'd0;
            rounds_left <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        in          <= preset;
                        rounds_left <= rounds;
                    end
                end
                LOAD: begin
                    if (abort) rounds_left <= 4'd0;
                end
                RUN: begin
                    if (abort)
                        rounds_left <= 4'd0;
                    else if (tcount && (rounds_left != 4'd0))
                        rounds_left <= rounds_left - 4'd1;  // saturates at 0
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the state register alone.
    always_comb begin
        ld   = 1'b0;
        cnt  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            LOAD: begin ld  = 1'b1; busy = 1'b1; end
            RUN:  begin cnt = 1'b1; busy = 1'b1; end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cnt_sequencer.sv
// Bench for cnt_sequencer: attaches a 4-bit up-counter and checks every cycle
// of each run against closed-form expectations derived from preset/rounds.
module tb_cnt_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] preset;
    logic [3:0] rounds;
    logic       tcount;
    logic [3:0] cnt_in;
    logic       ld;
    logic       cnt;
    logic       busy;
    logic       done;
    logic [3:0] rounds_left;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    cnt_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .preset     (preset),
        .rounds     (rounds),
        .tcount     (tcount),
        .in         (cnt_in),
        .ld         (ld),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done),
        .rounds_left(rounds_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit up-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     count <= 4'd0;
        else if (ld)  count <= cnt_in;
        else if (cnt) count <= count + 4'd1;
    end
    assign tcount = (count == 4'hF);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic e_ld, input logic e_cnt,
                             input logic e_busy, input logic e_done, input int e_rl,
                             input int e_in);
        check({tag, ".ld"},   8'(ld),   8'(e_ld));
        check({tag, ".cnt"},  8'(cnt),  8'(e_cnt));
        check({tag, ".busy"}, 8'(busy), 8'(e_busy));
        check({tag, ".done"}, 8'(done), 8'(e_done));
        check({tag, ".rl"},   8'(rounds_left), 8'(e_rl));
        check({tag, ".in"},   8'(cnt_in), 8'(e_in));
    endtask

    // One sequence, entered and left at a negedge in IDLE.
    // Cycle t=1 is LOAD; RUN spans t=2..n+1 with n=(16-p)+16*(r-1); DONE is t=n+2.
    // abort_t>0 holds abort through cycle abort_t. noise toggles start/preset/rounds
    // while active. idle_abort raises abort together with the accepting start.
    task automatic run_seq(input int p, input int r, input int abort_t,
                           input bit noise, input bit idle_abort);
        int  n;
        int  j;
        bit  aborted;
        n = (r == 0) ? 0 : (16 - p) + 16 * (r - 1);
        aborted = 1'b0;
        preset = 4'(p);
        rounds = 4'(r);
        start  = 1'b1;
        abort  = idle_abort;
        @(negedge clk);
        for (int t = 1; t <= n + 2; t++) begin
            if (t == 1) begin
                check_ctl("load", 1'b1, 1'b0, 1'b1, 1'b0, r, p);
            end else if (t <= n + 1) begin
                j = t - 2;
                check_ctl("run", 1'b0, 1'b1, 1'b1, 1'b0, r - (p + j) / 16, p);
                check("run.count", 8'(count), 8'((p + j) % 16));
            end else begin
                check_ctl("done", 1'b0, 1'b0, 1'b0, 1'b1, 0, p);
                check("done.count", 8'(count), 8'((r == 0) ? p : 0));
            end
            if (noise) begin
                start  = 1'($urandom);
                preset = 4'($urandom);
                rounds = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            abort = (t == abort_t);
            @(negedge clk);
            if (t == abort_t) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check_ctl(aborted ? "post_abort" : "post_done", 1'b0, 1'b0, 1'b0, 1'b0, 0, p);
        if (!aborted)
            check("idle.count", 8'(count), 8'((r == 0) ? p : 0));
    endtask

    int rp, rr, rn, rat;

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        preset = 4'd0;
        rounds = 4'd0;

        // Reset held: outputs zero before and across clock edges, start ignored.
        #2;
        check_ctl("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        start  = 1'b1;
        preset = 4'hA;
        rounds = 4'd3;
        #9;
        check_ctl("rst11", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        #8;
        check_ctl("rst19", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("rst.count", 8'(count), 8'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check_ctl("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Directed runs.
        run_seq(12, 1, 0, 1'b0, 1'b0);   // four RUN cycles, done in cycle 6
        run_seq(14, 3, 0, 1'b0, 1'b0);   // 34 RUN cycles
        run_seq(5,  0, 0, 1'b0, 1'b0);   // load only
        run_seq(3,  2, 4, 1'b1, 1'b0);   // abort in 3rd RUN cycle, start noise
        run_seq(7,  2, 1, 1'b0, 1'b0);   // abort during LOAD
        run_seq(15, 1, 0, 1'b0, 1'b1);   // abort in IDLE is ignored

        // Reset asserted between edges in the middle of RUN.
        preset = 4'd2;
        rounds = 4'd2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid.cnt", 8'(cnt), 8'd1);
        #2;
        rst = 1'b0;
        #1;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("async_rst.count", 8'(count), 8'd0);
        @(negedge clk);
        check_ctl("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_ctl("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_seq(9, 2, 0, 1'b0, 1'b0);

        // Randomized runs.
        repeat (20) begin
            rp  = int'($urandom_range(0, 15));
            rr  = int'($urandom_range(0, 3));
            rn  = (rr == 0) ? 0 : (16 - rp) + 16 * (rr - 1);
            rat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rn + 1)) : 0;
            run_seq(rp, rr, rat, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_sequencer.md
CNT_SEQUENCER -- requirements
Module: cnt_sequencer

Interface
REQ-001: The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  asynchronous active-low reset; 0 forces the reset state immediately.
REQ-004: start  input  1  begins a sequence when sampled high in IDLE.
REQ-005: abort  input  1  terminates an active sequence without done.
REQ-006: preset  input  4  load value, captured on the accepting start edge.
REQ-007: rounds  input  4  number of terminal counts to wait, captured with preset; 0 = load only.
REQ-008: tcount  input  1  terminal-count flag from the downstream 4-bit up-counter (high when its count = 1111).
REQ-009: in  output  4  load value driven to the up-counter's in port.
REQ-010: ld  output  1  load strobe to the up-counter.
REQ-011: cnt  output  1  count enable to the up-counter.
REQ-012: busy  output  1  high in LOAD and RUN.
REQ-013: done  output  1  single-cycle completion pulse.
REQ-014: rounds_left  output  4  remaining terminal counts in the active sequence.

Function
REQ-015: The block SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-016: ld, cnt, busy and done SHALL be Moore outputs decoded from the state register only.
REQ-017: IDLE: ld=0, cnt=0, busy=0, done=0; start=1 at an edge captures preset into the in register and rounds into rounds_left, then moves to LOAD.
REQ-018: Start SHALL be ignored in LOAD, RUN and DONE; the captured values SHALL NOT change outside IDLE.
REQ-019: LOAD: ld=1, cnt=0, busy=1 for exactly one cycle; next state is DONE if rounds_left=0, else RUN.
REQ-020: RUN: ld=0, cnt=1, busy=1; on each edge with tcount=1, rounds_left SHALL decrement by 1.
REQ-021: RUN: an edge with tcount=1 and rounds_left=1 SHALL set rounds_left to 0 and move to DONE; the counter wraps 1111->0000 on that same edge.
REQ-022: DONE: done=1, busy=0, ld=0, cnt=0 for exactly one cycle, then IDLE unconditionally.
REQ-023: abort=1 at an edge in LOAD or RUN SHALL move to IDLE with no done pulse and SHALL clear rounds_left to 0; abort has priority over tcount.
REQ-024: abort SHALL have no effect in IDLE or DONE.
REQ-025: The in output SHALL hold the captured preset until the next accepted start.
REQ-026: rounds_left SHALL never wrap below 0.
REQ-027: Start-to-done latency with rounds=R>0 and preset=P SHALL be 1 (LOAD) + (16-P) + 16*(R-1) RUN cycles + 1; done is high in cycle (16-P)+16*(R-1)+2 after the accepting edge.

Reset
REQ-028: While rst=0 the block SHALL be in IDLE with in=0000, rounds_left=0000, ld=0, cnt=0, busy=0, done=0, independent of clk.
REQ-029: rst asserted mid-LOAD or mid-RUN SHALL abandon the sequence with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification (bench attaches the 4-bit up-counter: count, tcount, in, ld, cnt, clk, rst)
REQ-030: rst=0 for 11 ns -> all outputs 0, state IDLE; no change on clk edges while held.
REQ-031: preset=1100, rounds=0001, one-cycle start -> ld=1 for 1 cycle, cnt=1 for 4 cycles (count 1100,1101,1110,1111), done=1 in the 6th cycle, count=0000, busy=0 after.
REQ-032: preset=1110, rounds=0011 -> RUN lasts 34 cycles; rounds_left 3->2->1->0 at each tcount edge; exactly one done pulse.
REQ-033: preset=0101, rounds=0000 -> LOAD 1 cycle, then DONE; cnt never asserted; count stays 0101.
REQ-034: rounds=0010, abort=1 in the 3rd RUN cycle -> IDLE next edge, cnt=0, done never asserted, rounds_left=0; a start pulse during RUN is ignored.
REQ-035: rst driven 0 mid-RUN between clk edges -> ld, cnt, busy drop to 0 immediately; new start after release runs a full sequence correctly.
